// File: rtl/alu_scheduler.sv
// rtl/alu_scheduler.sv - round-robin sequencer sharing one combinational ALU between two requesters
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req0_* / req1_*              requester ports: valid/ready handshake, operands a/b, ALU ctrl code
//   alu_a, alu_b, alu_ctrl       registered operand/control drive to the ALU
//   alu_result, alu_zero         combinational result from the ALU
//   rsp0_valid, rsp1_valid       one-cycle response pulse to the owning requester
//   rsp_result, rsp_zero, rsp_div0  shared response data, valid with either pulse
//   busy                         high while an operation is executing
module alu_scheduler #(
   parameter int MULDIV_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [3:0]  req0_ctrl,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [3:0]  req1_ctrl,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_ctrl,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic        rsp0_valid,
   output logic        rsp1_valid,
   output logic [31:0] rsp_result,
   output logic        rsp_zero,
   output logic        rsp_div0,
   output logic        busy
);

   localparam logic [3:0] CTRL_MUL = 4'b0101;
   localparam logic [3:0] CTRL_DIV = 4'b1011;
   localparam logic [3:0] CTRL_ADD = 4'b0010;
   localparam logic [3:0] CNT_LOAD = 4'(MULDIV_CYCLES - 1);

   typedef enum logic {IDLE, EXEC} state_t;

   state_t     state;
   logic       last_grant;
   logic       owner;
   logic [3:0] cnt;

   logic        in_idle;
   logic        grant0;
   logic        grant1;
   logic [31:0] sel_a;
   logic [31:0] sel_b;
   logic [3:0]  sel_ctrl;
   logic        div0;

   // rst_n gates ready so no grant is shown while reset is still held.
   assign in_idle = (state == IDLE) && rst_n;

   // On contention the port not granted last wins; a lone requester always wins.
   assign grant0 = in_idle && req0_valid && (!req1_valid || last_grant);
   assign grant1 = in_idle && req1_valid && (!req0_valid || !last_grant);

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   assign sel_a    = grant1 ? req1_a    : req0_a;
   assign sel_b    = grant1 ? req1_b    : req0_b;
   assign sel_ctrl = grant1 ? req1_ctrl : req0_ctrl;

   assign div0 = (alu_ctrl == CTRL_DIV) && (alu_b == 32'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         cnt        <= 4'd0;
         alu_a      <= 32'd0;
         alu_b      <= 32'd0;
         alu_ctrl   <= CTRL_ADD;
         rsp_result <= 32'd0;
         rsp_zero   <= 1'b0;
         rsp_div0   <= 1'b0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         if (state == IDLE) begin
            if (grant0 || grant1) begin
               alu_a      <= sel_a;
               alu_b      <= sel_b;
               alu_ctrl   <= sel_ctrl;
               owner      <= grant1;
               last_grant <= grant1;
               cnt        <= ((sel_ctrl == CTRL_MUL) || (sel_ctrl == CTRL_DIV)) ? CNT_LOAD : 4'd0;
               busy       <= 1'b1;
               state      <= EXEC;
            end
         end else begin
            if (cnt != 4'd0) begin
               cnt <= cnt - 4'd1;
            end else begin
               // Divide by zero returns all-ones regardless of what the ALU produced.
               rsp_result <= div0 ? 32'hFFFF_FFFF : alu_result;
               rsp_zero   <= div0 ? 1'b0 : alu_zero;
               rsp_div0   <= div0;
               rsp0_valid <= !owner;
               rsp1_valid <= owner;
               busy       <= 1'b0;
               state      <= IDLE;
            end
         end
      end
   end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Sequencing arbiter that shares the single combinational `ALU` between two requesters: port 0, the core datapath, and port 1, the auxiliary/coprocessor path. It accepts one operation at a time with round-robin arbitration and latches the operands onto the ALU inputs. It holds them for one cycle, or `MULDIV_CYCLES` cycles for multiply/divide, then returns the registered result and zero flag to the granted requester. It sits between the requesters and the `ALU` instance and owns the ALU inputs exclusively.

## Interface
- `MULDIV_CYCLES`, default 4: execute cycles held for alu_control 4'b0101 (mult) and 4'b1011 (div); legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req0_valid`, `req1_valid` in 1: the requester presents an operation.
- `req0_ready`, `req1_ready` out 1: grant; the operation is accepted when valid&ready.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in 32: operands.
- `req0_ctrl`, `req1_ctrl` in 4: ALU control code (ALU encoding).
- `alu_a`, `alu_b` out 32; `alu_ctrl` out 4: registered drive to the ALU.
- `alu_result` in 32; `alu_zero` in 1: from the ALU.
- `rsp0_valid`, `rsp1_valid` out 1: one-cycle response pulse to the owner.
- `rsp_result` out 32; `rsp_zero` out 1; `rsp_div0` out 1: shared response data, valid with either rsp pulse.
- `busy` out 1: high while the state is EXEC.

## Operation
- States are IDLE and EXEC.
- **IDLE**
  - `reqN_ready` is combinational: asserted only in IDLE, only for the arbitration winner.
  - Arbitration when both valid: grant the port not granted last. `last_grant` resets to 1, so port 0 wins the first contention.
  - Single valid: that port wins regardless of `last_grant`.
  - On accept:
    - latch a, b and ctrl into `alu_a`, `alu_b` and `alu_ctrl`;
    - record the owner;
    - update `last_grant`;
    - load `cnt` = MULDIV_CYCLES-1 for ctrl 0101/1011, else 0;
    - go to EXEC.
- **EXEC**
  - ALU inputs are held stable.
  - When cnt≠0: decrement.
  - When cnt==0, capture:
    - `rsp_result` = alu_result and `rsp_zero` = alu_zero;
    - `rsp_div0` = (ctrl==1011 && alu_b==0);
    - if div0, force `rsp_result` = 32'hFFFFFFFF and `rsp_zero` = 0;
    - set the owner's `rsp_valid` for the next cycle;
    - return to IDLE.
- Responses have no backpressure. A requester must sample on the pulse.
- `rsp_result`, `rsp_zero` and `rsp_div0` hold their last value until the next capture.
- Unknown ctrl codes are passed through unchanged; the ALU defaults them to add.
- A requester may drop valid before being granted; nothing is recorded.
- Valid and operands must be stable while waiting; the scheduler samples only on accept.

## Timing
- Reset values: `alu_a`, `alu_b`, `rsp_result` = 0; `alu_ctrl` = 4'b0010; `rsp0_valid`, `rsp1_valid`, `rsp_zero`, `rsp_div0`, `busy` = 0; `reqN_ready` = 0 until the first IDLE cycle after reset release; state IDLE; `last_grant` = 1; `cnt` = 0.
- Accept in cycle T. EXEC runs T+1 .. T+L, where L = 1 or MULDIV_CYCLES.
- The response pulse arrives in cycle T+L+1: latency 2 for simple ops, MULDIV_CYCLES+1 for mult/div.
- In the response cycle the state is IDLE, so a new accept may occur in that same cycle. Back-to-back throughput is one op per L+1 cycles.
- `rsp0_valid` and `rsp1_valid` are never high together. Each is high for exactly one cycle per accepted op.
- Reset asserted mid-EXEC: the op is abandoned immediately; no response is ever produced; all outputs take reset values asynchronously.
- Both valid in the response cycle: the arbiter grants the opposite of the op just finished.

## Test plan
- **Single add.** Port 0: a=5, b=7, ctrl=0010 accepted at T. Required: `rsp0_valid` high only at T+2, `rsp_result`=12, `rsp_zero`=0, `busy` high at T+1 only.
- **Multiply latency.** MULDIV_CYCLES=4; port 1: a=6, b=7, ctrl=0101. Required: `rsp1_valid` at T+5, `rsp_result`=42, `alu_a`/`alu_b` stable T+1..T+4.
- **Contention.** Both valid continuously with ctrl=0110 (sub, a=b=3). Required: grants go 0,1,0,1; accepts every 2 cycles; each response has `rsp_zero`=1 and targets the correct port.
- **Divide by zero.** Port 0: a=10, b=0, ctrl=1011. Required: `rsp_result`=32'hFFFFFFFF, `rsp_div0`=1, `rsp_zero`=0. A following div 10/2 returns 5 with `rsp_div0`=0.
- **Reset mid-op.** rst_n pulsed low during EXEC of a mult. Required: no rsp pulse, outputs at reset values, and the next contention grants port 0 first.
- **Accept in response cycle.** Port 1 valid when port 0's response pulses. Required: `req1_ready` high in that same cycle; port 1's response follows L+1 cycles later.
